// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/done handshake and operand/result bus
// for the bit-serial adder. SERIAL_ADDER_SUB_EN adds the sub request bit.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start,
    output a,
    output b,
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy,
    input  done,
    input  sum,
    input  carry_out
  );

  modport slave (
    input  start,
    input  a,
    input  b,
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy,
    output done,
    output sum,
    output carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: one full-adder slice reused LSB-first over WIDTH bits.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] b_ld;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             c_ld;
  logic             co_q;
  logic             p;
  logic             g1;
  logic             g2;
  logic             s;
  logic             cn;
  logic             last;

  // two half-adder cells plus the carry OR
  always_comb begin
    p     = ra[0] ^ rb[0];
    g1    = ra[0] & rb[0];
    s     = p ^ c;
    g2    = p & c;
    cn    = g1 | g2;
    res_n = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
    last  = (cnt == CW'(WIDTH - 1));
  end

`ifdef SERIAL_ADDER_SUB_EN
  // subtract as a + ~b + 1
  assign b_ld = bus.sub ? ~bus.b : bus.b;
  assign c_ld = bus.sub;
`else
  assign b_ld = bus.b;
  assign c_ld = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      res   <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            ra    <= bus.a;
            rb    <= b_ld;
            c     <= c_ld;
            cnt   <= '0;
            state <= RUN;
          end
        end
        (state == RUN): begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          res <= res_n;
          c   <= cn;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum_q <= res_n;
            co_q  <= cn;
            state <= DONE;
          end
        end
        (state == DONE): state <= IDLE;
        default:         state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench, random and directed operations
// on a WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [W:0] q[$];
  logic [W:0] held = '0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) m();
  serial_adder_ctrl_if #(.WIDTH(1)) m1();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m1.slave)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // reference: plain integer add / subtract
  function automatic logic [W:0] model(logic [W-1:0] av, logic [W-1:0] bv,
                                       logic sb);
    longint x = av;
    longint y = bv;
    logic [W-1:0] d;
    if (sb) begin
      d = W'(x - y);
      return {(x >= y), d};
    end
    return (W+1)'(x + y);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_sub(logic sb);
`ifdef SERIAL_ADDER_SUB_EN
    m.sub = sb;
`else
    if (sb) $display("note: sub ignored");
`endif
  endtask

  task automatic junk();
    m.start = 1'($urandom);
    m.a = W'($urandom);
    m.b = W'($urandom);
    set_sub(1'($urandom));
  endtask

  // must be entered in an IDLE cycle; returns in the next IDLE cycle
  task automatic run_op(logic [W-1:0] av, logic [W-1:0] bv, logic sb,
                        bit hold);
    m.start = 1'b1;
    m.a = av;
    m.b = bv;
    set_sub(sb);
`ifdef SERIAL_ADDER_SUB_EN
    q.push_back(model(av, bv, sb));
`else
    q.push_back(model(av, bv, 1'b0));
`endif
    for (int i = 0; i < W; i++) begin
      tick();
      chk("busy_phase", {62'd0, m.busy, m.done}, 64'd2);
      junk();
      if (hold) m.start = 1'b1;
    end
    tick();
    chk("done_phase", {62'd0, m.busy, m.done}, 64'd1);
    junk();
    if (hold) m.start = 1'b1;
    tick();
    chk("idle_phase", {62'd0, m.busy, m.done}, 64'd0);
  endtask

  task automatic idle();
    m.start = 1'b0;
    tick();
    chk("idle_gap", {62'd0, m.busy, m.done}, 64'd0);
  endtask

  task automatic abort_op(logic [W-1:0] av, logic [W-1:0] bv);
    m.start = 1'b1;
    m.a = av;
    m.b = bv;
    set_sub(1'b0);
    q.push_back(model(av, bv, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      junk();
    end
    rst_n = 1'b0;
    tick();
    chk("abort_out", {m.busy, m.done, m.carry_out, m.sum}, 64'd0);
    rst_n = 1'b1;
    m.start = 1'b0;
    tick();
    chk("abort_idle", {62'd0, m.busy, m.done}, 64'd0);
  endtask

  // monitor: pops the scoreboard on done, otherwise results must hold
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst_n) begin
      q.delete();
      held = '0;
      chk("reset_out", {m.busy, m.done, m.carry_out, m.sum}, 64'd0);
    end else begin
      chk("busy_and_done", {63'd0, m.busy & m.done}, 64'd0);
      if (m.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("result", {m.carry_out, m.sum}, e);
          held = e;
        end
      end else begin
        chk("held_result", {m.carry_out, m.sum}, held);
      end
    end
  end

  initial begin
    logic [1:0] e1;
    int nsub;
    m.start = 1'b1;
    m.a = 8'h12;
    m.b = 8'h34;
    set_sub(1'b0);
    m1.start = 1'b0;
    m1.a = 1'b0;
    m1.b = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    m1.sub = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    m.start = 1'b0;
    tick();
    chk("post_reset", {m.busy, m.done, m.carry_out, m.sum}, 64'd0);

    run_op(8'hA5, 8'h5A, 1'b0, 1'b0);
    idle();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    idle();
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    idle();
    run_op(8'h10, 8'h20, 1'b0, 1'b0);
    idle();
    idle();
    abort_op(8'h55, 8'h66);
    run_op(8'h33, 8'h44, 1'b0, 1'b0);
    idle();
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b0);
    idle();
    run_op(8'h07, 8'h05, 1'b1, 1'b0);
    idle();
`endif
    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    chk("queue_empty", 64'(q.size()), 64'd0);

    // WIDTH=1 instance: done two cycles after start
`ifdef SERIAL_ADDER_SUB_EN
    nsub = 2;
`else
    nsub = 1;
`endif
    for (int sb = 0; sb < nsub; sb++) begin
      for (int k = 0; k < 4; k++) begin
        m1.start = 1'b1;
        m1.a = 1'(k >> 1);
        m1.b = 1'(k);
`ifdef SERIAL_ADDER_SUB_EN
        m1.sub = 1'(sb);
`endif
        if (sb == 1) e1 = {(k >> 1) >= (k & 1), 1'((k >> 1) - (k & 1))};
        else         e1 = 2'((k >> 1) + (k & 1));
        tick();
        m1.start = 1'b0;
        chk("w1_busy", {62'd0, m1.busy, m1.done}, 64'd2);
        tick();
        chk("w1_done", {62'd0, m1.busy, m1.done}, 64'd1);
        chk("w1_result", {62'd0, m1.carry_out, m1.sum}, 64'(e1));
        tick();
        chk("w1_idle", {62'd0, m1.busy, m1.done}, 64'd0);
        chk("w1_hold", {62'd0, m1.carry_out, m1.sum}, 64'(e1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Bit-serial add controller: time-shares one 1-bit full adder (two half-adder cells plus carry OR) across a WIDTH-bit operand pair.
- Processes one bit per clock, LSB first, under a start/done handshake.
- Sits between a requesting datapath and the adder cells; trades latency for area when a parallel adder is too large.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; sum/carry_out valid.
- sum  output  WIDTH  result; held until the next accepted start completes.
- carry_out  output  1  final carry; held with sum.

## Operation
- Reset (rst_n low at a clk edge): state=IDLE; busy=0, done=0, sum=0, carry_out=0; internal operand shift registers, carry flop and bit counter cleared.
- States:
  - IDLE: start=1 → latch a, b into shift registers, carry flop=0, counter=0, go to RUN. start=0 → stay in IDLE.
  - RUN: each cycle, add bit0 of A, bit0 of B and the carry flop. The half-adder pair gives s = a^b^c and c' = (a&b)|((a^b)&c). Shift s into the result register at the MSB end; shift A and B right; carry flop=c'; counter++. On the cycle with counter==WIDTH-1, load sum=result (final bit included) and carry_out=c', then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Always return to IDLE; start is ignored in DONE.
- start, a and b are ignored outside IDLE. Changes to a/b after acceptance do not affect the result.
- Arithmetic: {carry_out,sum} = a + b modulo 2^(WIDTH+1). No sign interpretation.
- sum/carry_out change only on the RUN→DONE transition or on reset.
- Reset mid-RUN or in DONE: abort with no done pulse; all outputs return to 0.
- WIDTH=1: RUN lasts one cycle (counter==0==WIDTH-1).

## Timing
- Accepted start at edge k:
  - busy=1 for cycles k+1..k+WIDTH.
  - sum/carry_out update and done=1 at cycle k+WIDTH+1.
  - IDLE again at k+WIDTH+2.
- Latency from accepted start to done: WIDTH+1 cycles.
- Maximum issue rate: one operation per WIDTH+2 cycles. start may be held high continuously; it is re-accepted in each IDLE cycle.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds an input port `sub` (1 bit), captured with the operands on an accepted start.
  - sub=1: B is inverted as it is latched and the carry flop is initialised to 1, giving sum = a - b mod 2^WIDTH. carry_out=1 means no borrow (a ≥ b unsigned).
  - sub=0: identical to add.
- Not defined: no `sub` port; add only, carry flop initialised to 0.

## Test plan
- Reset: hold rst_n=0 two cycles with start=1 → busy=0, done=0, sum=0, carry_out=0 throughout; after release, the first accepted start completes normally.
- WIDTH=8, a=0xA5, b=0x5A, start pulse at edge k → busy high k+1..k+8; done=1 only at k+9 with sum=0xFF, carry_out=0.
- a=0xFF, b=0x01 → sum=0x00, carry_out=1. Then a=0x00, b=0x00 → sum=0x00, carry_out=0, with the previous result held until that done.
- start pulsed with a=0x11 at cycles k+3 and k+9 (RUN/DONE) of an operation on 0x10+0x20 → single done with sum=0x30; no second operation starts.
- rst_n=0 at RUN cycle k+4 → next cycle busy=0, done never pulses, sum=0; a new start then gives the correct result (0x33+0x44 → 0x77).
- SERIAL_ADDER_SUB_EN: sub=1, a=0x05, b=0x07 → sum=0xFE, carry_out=0; a=0x07, b=0x05 → sum=0x02, carry_out=1. Repeat WIDTH=1 with a=1, b=1 (add) → sum=0, carry_out=1, done two cycles after start.
